// File: rtl/proc_pkg.sv
// Shared processor definitions: data width, instruction constants, opcode map
// and the fetch controller state encoding.
package proc_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// In-order instruction buffer holding {pc, instr} pairs. Entry 0 is always the
// head, so the head is a plain register and holds its last value once drained.
module fetch_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [XLEN-1:0]  push_pc,
    input  logic [XLEN-1:0]  push_instr,
    input  logic             pop,
    input  logic             flush,
    output logic [XLEN-1:0]  head_pc,
    output logic [XLEN-1:0]  head_instr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int ENTRY_W = 2 * XLEN;

    logic [CNT_W-1:0]   count_reg;
    logic [ENTRY_W-1:0] entry_q [DEPTH];
    logic               do_push;
    logic               do_pop;
    logic [CNT_W-1:0]   wr_idx;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    // flush wins over both; a push into a full buffer only lands if a pop frees a slot
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    // new entry goes just behind the last surviving entry
    assign wr_idx  = count_reg - CNT_W'(do_pop);

    assign head_pc    = entry_q[0][ENTRY_W-1:XLEN];
    assign head_instr = entry_q[0][XLEN-1:0];
    assign count      = count_reg;

    // Occupancy counter; flush empties the buffer but leaves entry contents alone
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (flush) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_reg;
            logic [ENTRY_W-1:0] shift_src;
            logic               shift_en;

            if (gi < DEPTH - 1) begin : g_shift
                // only shift live entries so a drained head keeps its last value
                assign shift_src = entry_q[gi+1];
                assign shift_en  = do_pop & (CNT_W'(gi + 1) < count_reg);
            end else begin : g_last
                assign shift_src = entry_reg;
                assign shift_en  = 1'b0;
            end

            assign entry_q[gi] = entry_reg;

            // Per-slot storage: take the pushed word or shift toward the head on pop
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    entry_reg <= '0;
                end else if (do_push && (wr_idx == CNT_W'(gi))) begin
                    entry_reg <= {push_pc, push_instr};
                end else if (shift_en) begin
                    entry_reg <= shift_src;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word fetches under a credit limit, tags
// in-order responses with their PC, buffers them and presents the head to
// decode. Redirects flush the buffer and drop responses still in flight.
module instr_fetch_unit #(
    parameter int              XLEN      = proc_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ir_valid,
    input  logic            ir_ready,
    output logic [XLEN-1:0] ir,
    output logic [XLEN-1:0] ir_pc
);

    import proc_pkg::*;

    localparam int              CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(INSTR_BYTES);

    fetch_state_t     state_reg;
    logic [XLEN-1:0]  req_addr_reg;
    logic [XLEN-1:0]  resp_pc_reg;
    logic [CNT_W-1:0] outstanding_reg;
    logic [CNT_W-1:0] drop_cnt_reg;

    logic [CNT_W-1:0] buf_count;
    logic             buf_full;
    logic             buf_empty;
    logic             credit_ok;
    logic             req_fire;
    logic             rsp_drop;
    logic             buf_push;
    logic             buf_pop;
    logic [XLEN-1:0]  redirect_target;
    logic [CNT_W-1:0] redirect_drop;
    logic             redirect_lsb_unused;

    // in-flight requests plus buffered words may never exceed the buffer size,
    // which is what guarantees room for every response
    assign credit_ok      = ({1'b0, outstanding_reg} + {1'b0, buf_count}) < DEPTH_C;
    assign imem_req_valid = (state_reg != S_BOOT) & ~redirect_valid & credit_ok;
    assign imem_req_addr  = req_addr_reg;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_drop = imem_rsp_valid & (drop_cnt_reg != '0);
    assign buf_push = imem_rsp_valid & (drop_cnt_reg == '0) & ~redirect_valid;
    assign buf_pop  = ir_valid & ir_ready & ~redirect_valid;

    // target is forced word aligned; a response landing in the redirect cycle
    // is already stale and is not counted as still to drop
    assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc[1:0];
    assign redirect_drop       = outstanding_reg - CNT_W'(imem_rsp_valid);

    assign ir_valid = ~buf_empty;

    fetch_buffer #(
        .XLEN  (XLEN),
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (buf_push),
        .push_pc    (resp_pc_reg),
        .push_instr (imem_rsp_data),
        .pop        (buf_pop),
        .flush      (redirect_valid),
        .head_pc    (ir_pc),
        .head_instr (ir),
        .count      (buf_count),
        .full       (buf_full),
        .empty      (buf_empty)
    );

    // Fetch FSM with request/response address tracking and in-flight accounting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= S_BOOT;
            req_addr_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            outstanding_reg <= outstanding_reg + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
            if (redirect_valid) begin
                req_addr_reg <= redirect_target;
                resp_pc_reg  <= redirect_target;
                drop_cnt_reg <= redirect_drop;
                state_reg    <= (redirect_drop != '0) ? S_DRAIN : S_RUN;
            end else begin
                if (req_fire) begin
                    req_addr_reg <= req_addr_reg + STEP;
                end
                if (buf_push) begin
                    resp_pc_reg <= resp_pc_reg + STEP;
                end
                if (rsp_drop) begin
                    drop_cnt_reg <= drop_cnt_reg - 1'b1;
                end
                case (state_reg)
                    S_BOOT:  state_reg <= S_RUN;
                    S_RUN:   state_reg <= S_RUN;
                    S_DRAIN: begin
                        if ((drop_cnt_reg == '0) ||
                            (rsp_drop && (drop_cnt_reg == CNT_W'(1)))) begin
                            state_reg <= S_RUN;
                        end
                    end
                    default: state_reg <= S_BOOT;
                endcase
            end
        end
    end

    // Invariants: responses only for issued requests, drops never exceed
    // in-flight requests, and credits keep the buffer from overflowing
    always @(posedge clk) begin
        if (reset) begin
            assert (!(imem_rsp_valid && (outstanding_reg == '0)));
            assert (drop_cnt_reg <= outstanding_reg);
            assert (!(buf_push && buf_full));
        end
    end

endmodule
